cgra_alu_pe: RTL and testbench

- Configurable CGRA processing-element slice with three parts:
  - 4x4 fully-connected input switch;
  - two-input registered ALU;
  - 2x1 output switch.
- A serial configuration chain sets the ALU opcode and all switch selects.
- Tiles are chained config_out→config_in to form the fabric configuration scan path.

---
 rtl/cgra_pkg.sv | 48 ++++
 rtl/cgra_alu.sv | 57 +++++
 rtl/cgra_alu_pe.sv | 83 ++++++++
 tb/tb_cgra_alu_pe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared constants and config-word layout for the CGRA ALU processing element.
package cgra_pkg;

    localparam int unsigned CFG_W = 13;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned SEL_W = 2;

    // Bit offsets of each field inside the config word
    localparam int unsigned CFG_OP_LSB   = 0;
    localparam int unsigned CFG_OSEL_BIT = 4;
    localparam int unsigned CFG_SEL0_LSB = 5;
    localparam int unsigned CFG_SEL1_LSB = 7;
    localparam int unsigned CFG_SEL2_LSB = 9;
    localparam int unsigned CFG_SEL3_LSB = 11;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd8;
    localparam logic [OP_W-1:0] OP_EQ   = 4'd9;
    localparam logic [OP_W-1:0] OP_LT   = 4'd10;
    localparam logic [OP_W-1:0] OP_LTU  = 4'd11;
    localparam logic [OP_W-1:0] OP_PASS = 4'd12;
    localparam logic [OP_W-1:0] OP_MIN  = 4'd13;
    localparam logic [OP_W-1:0] OP_MAX  = 4'd14;
    localparam logic [OP_W-1:0] OP_ZERO = 4'd15;

    localparam logic [SEL_W-1:0] SRC_IN0 = 2'd0;
    localparam logic [SEL_W-1:0] SRC_IN1 = 2'd1;
    localparam logic [SEL_W-1:0] SRC_ALU = 2'd2;
    localparam logic [SEL_W-1:0] SRC_IN2 = 2'd3;

    // Field order matches the bit offsets above (sel3 in the MSBs, opcode in the LSBs)
    typedef struct packed {
        logic [SEL_W-1:0] sel3;
        logic [SEL_W-1:0] sel2;
        logic [SEL_W-1:0] sel1;
        logic [SEL_W-1:0] sel0;
        logic             osel;
        logic [OP_W-1:0]  op;
    } cfg_t;

endpackage

// File: rtl/cgra_alu.sv
// Two-operand ALU with a single result register (one cycle latency).
module cgra_alu
    import cgra_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      i_op,
    input  logic [size-1:0]      i_a,
    input  logic [size-1:0]      i_b,
    output logic [size-1:0]      o_q
);

    localparam int unsigned W = size;

    logic [W-1:0] w_res;
    logic [4:0]   w_shamt;
    logic         w_lt_s;
    logic         w_lt_u;

    assign w_shamt = i_b[4:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;

    // Opcode decode
    always_comb begin
        w_res = '0;
        case (i_op)
            OP_ADD:  w_res = i_a + i_b;
            OP_SUB:  w_res = i_a - i_b;
            OP_MUL:  w_res = i_a * i_b;
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_SHL:  w_res = i_a << w_shamt;
            OP_SHR:  w_res = i_a >> w_shamt;
            OP_SRA:  w_res = W'($signed(i_a) >>> w_shamt);
            OP_EQ:   w_res = W'(i_a == i_b);
            OP_LT:   w_res = W'(w_lt_s);
            OP_LTU:  w_res = W'(w_lt_u);
            OP_PASS: w_res = i_a;
            OP_MIN:  w_res = w_lt_s ? i_a : i_b;
            OP_MAX:  w_res = w_lt_s ? i_b : i_a;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_q <= '0;
        end else begin
            o_q <= w_res;
        end
    end

endmodule

// File: rtl/cgra_alu_pe.sv
// CGRA processing element: 4x4 input switch, registered ALU, 2x1 output switch,
// all configured through a 13-bit serial scan chain.
module cgra_alu_pe
    import cgra_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] in2,
    output logic [size-1:0] out0,
    output logic [size-1:0] route0,
    output logic [size-1:0] route1
);

    localparam int unsigned W = size;

    cfg_t         r_cfg;
    logic [W-1:0] w_alu_q;
    logic [W-1:0] w_sw0;
    logic [W-1:0] w_sw1;
    logic [W-1:0] w_sw2;
    logic [W-1:0] w_sw3;

    function automatic logic [W-1:0] pick_src(
        input logic [SEL_W-1:0] sel,
        input logic [W-1:0]     a0,
        input logic [W-1:0]     a1,
        input logic [W-1:0]     aq,
        input logic [W-1:0]     a2
    );
        logic [W-1:0] v;
        v = a0;
        case (sel)
            SRC_IN0: v = a0;
            SRC_IN1: v = a1;
            SRC_ALU: v = aq;
            SRC_IN2: v = a2;
            default: v = a0;
        endcase
        return v;
    endfunction

    // Scan chain: first bit in ends up in the MSB after a full load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg <= '0;
        end else if (config_en) begin
            r_cfg <= cfg_t'({r_cfg[CFG_W-2:0], config_in});
        end
    end

    assign config_out = r_cfg[CFG_W-1];

    // Input switch; the ALU source is the registered result, so no comb loop
    always_comb begin
        w_sw0 = pick_src(r_cfg.sel0, in0, in1, w_alu_q, in2);
        w_sw1 = pick_src(r_cfg.sel1, in0, in1, w_alu_q, in2);
        w_sw2 = pick_src(r_cfg.sel2, in0, in1, w_alu_q, in2);
        w_sw3 = pick_src(r_cfg.sel3, in0, in1, w_alu_q, in2);
    end

    cgra_alu #(
        .size (W)
    ) u_alu (
        .clk   (clk),
        .reset (reset),
        .i_op  (r_cfg.op),
        .i_a   (w_sw0),
        .i_b   (w_sw1),
        .o_q   (w_alu_q)
    );

    assign route0 = w_sw2;
    assign route1 = w_sw3;
    assign out0   = r_cfg.osel ? w_sw2 : w_alu_q;

endmodule

// File: tb/tb_cgra_alu_pe.sv
// Directed self-checking bench for cgra_alu_pe with a queue scoreboard on out0.
module tb_cgra_alu_pe;
    import cgra_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         config_en;
    logic         config_in;
    logic         config_out;
    logic [W-1:0] in0, in1, in2;
    logic [W-1:0] out0, route0, route1;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    cgra_alu_pe #(.size(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .out0       (out0),
        .route0     (route0),
        .route1     (route1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %h expected scoreboard entry (queue empty)", tag, out0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, out0, e);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk_cfg(
        input logic [3:0] op, input logic osel,
        input logic [1:0] s0, input logic [1:0] s1,
        input logic [1:0] s2, input logic [1:0] s3
    );
        return {s3, s2, s1, s0, osel, op};
    endfunction

    task automatic load_cfg(input logic [CFG_W-1:0] word);
        for (int i = CFG_W - 1; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = word[i];
            step();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
        load_cfg(mk_cfg(op, 1'b0, SRC_IN0, SRC_IN1, SRC_IN0, SRC_IN0));
        in0 = a;
        in1 = b;
        push_exp(exp);
        step();
        pop_chk(tag);
    endtask

    initial begin
        logic [CFG_W-1:0] w;
        reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;

        // Reset state
        #12;
        chk("rst_out0", out0, '0);
        chk("rst_cfg_out", W'(config_out), '0);
        step();
        in0 = 32'd7;
        reset = 1'b1;
        push_exp(32'd14);
        step();
        pop_chk("post_rst_add7");

        // Reset mid-operation, then release with in0=5
        #3 reset = 1'b0;
        #1;
        chk("midrst_out0", out0, '0);
        chk("midrst_cfg_out", W'(config_out), '0);
        chk("midrst_route0", route0, 32'd7);
        chk("midrst_route1", route1, 32'd7);
        in0 = 32'd5;
        step();
        reset = 1'b1;
        push_exp(32'd10);
        step();
        pop_chk("rst_release_add5");

        // Config load: SUB in0-in1
        w = mk_cfg(OP_SUB, 1'b0, SRC_IN0, SRC_IN1, SRC_IN0, SRC_IN0);
        load_cfg(w);
        in0 = 32'd3;
        in1 = 32'd5;
        push_exp(32'hFFFF_FFFE);
        step();
        pop_chk("sub_3_5");

        // Replay of loaded bits on config_out
        for (int i = 0; i < int'(CFG_W); i++) begin
            chk($sformatf("replay_bit%0d", CFG_W - 1 - i), W'(config_out), W'(w[CFG_W-1-i]));
            config_en = 1'b1;
            config_in = 1'b0;
            step();
        end
        config_en = 1'b0;

        // cfg is all-zero now: settle alu_q to 0 with zero inputs
        in0 = '0; in1 = '0; in2 = '0;
        push_exp('0);
        step();
        pop_chk("settle_zero");

        // Feedback accumulator
        load_cfg(mk_cfg(OP_ADD, 1'b0, SRC_ALU, SRC_IN1, SRC_IN0, SRC_IN0));
        in1 = 32'd1;
        for (int i = 1; i <= 5; i++) begin
            push_exp(W'(i));
            step();
            pop_chk($sformatf("acc_%0d", i));
        end
        #2 reset = 1'b0;
        #1;
        chk("acc_rst_out0", out0, '0);
        step();
        reset = 1'b1;
        in1 = '0;
        push_exp('0);
        step();
        pop_chk("acc_after_rst");

        // Opcode checks
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        run_op("sra",      OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_op("shr",      OP_SHR, 32'h8000_0000, 32'd4, 32'h0800_0000);
        run_op("shl_b5",   OP_SHL, 32'd1, 32'h0000_0023, 32'd8);
        run_op("lt_s",     OP_LT,  32'hFFFF_FFFF, 32'd1, 32'd1);
        run_op("ltu",      OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("mul_ovf",  OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
        run_op("mul",      OP_MUL, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
        run_op("and",      OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        run_op("or",       OP_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        run_op("eq",       OP_EQ,  32'd5, 32'd5, 32'd1);
        run_op("eq_ne",    OP_EQ,  32'd5, 32'd6, 32'd0);
        run_op("min_s",    OP_MIN, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFE);
        run_op("max_s",    OP_MAX, 32'hFFFF_FFFE, 32'd3, 32'd3);
        run_op("pass",     OP_PASS, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF);
        run_op("zero",     OP_ZERO, 32'd1, 32'd2, 32'd0);

        // Routing through the output switch (combinational)
        load_cfg(mk_cfg(OP_ZERO, 1'b1, SRC_IN0, SRC_IN1, SRC_IN2, SRC_IN1));
        in2 = 32'h0000_00A5;
        in1 = 32'h0000_003C;
        #1;
        chk("route0", route0, 32'h0000_00A5);
        chk("route_out0", out0, 32'h0000_00A5);
        chk("route1", route1, 32'h0000_003C);
        in2 = 32'h0000_005A;
        #1;
        chk("route_out0_comb", out0, 32'h0000_005A);

        // Config hold while config_in toggles
        load_cfg(mk_cfg(OP_XOR, 1'b0, SRC_IN0, SRC_IN1, SRC_IN2, SRC_IN2));
        in0 = 32'h0000_0F0F;
        in1 = 32'h0000_FF00;
        in2 = 32'h0000_0077;
        for (int i = 0; i < 20; i++) begin
            config_in = i[0];
            push_exp(32'h0000_F00F);
            step();
            pop_chk($sformatf("hold_xor_%0d", i));
        end
        chk("hold_cfg_out", W'(config_out), 32'd1);
        chk("hold_route0", route0, 32'h0000_0077);
        chk("hold_route1", route1, 32'h0000_0077);

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
